// File: rtl/hash_lut_loader_pkg.sv
// rtl/hash_lut_loader_pkg.sv - shared state type and address helpers for hash_lut_loader
package hash_lut_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } ldr_state_e;

  function automatic int unsigned clear_sweep_len(input int unsigned blocks,
                                                  input int unsigned addr_w);
    return blocks << addr_w;
  endfunction

  // Block index sits directly above the per-block bit address.
  function automatic logic [63:0] pack_lut_addr(input logic [31:0] block,
                                                input logic [31:0] addr,
                                                input int unsigned addr_w);
    return (64'(block) << addr_w) | 64'(addr);
  endfunction

endpackage

// File: rtl/lut_clear_sweeper.sv
// rtl/lut_clear_sweeper.sv - block-major address counter covering every LUT bit once
module lut_clear_sweeper
  import hash_lut_loader_pkg::*;
#(
  parameter int unsigned MEM_BLOCKS_CNT = 78,
  parameter int unsigned MEM_BLOCKS_W   = 13,
  parameter int unsigned BLK_W          = $clog2(MEM_BLOCKS_CNT)
) (
  input  logic                    clk_i,
  input  logic                    srst_n_i,
  input  logic                    start_i,
  output logic                    valid_o,
  output logic [BLK_W-1:0]        block_o,
  output logic [MEM_BLOCKS_W-1:0] addr_o,
  output logic                    last_o,
  output logic                    done_o
);

  localparam int unsigned CNT_W     = BLK_W + MEM_BLOCKS_W;
  localparam int unsigned SWEEP_LEN = clear_sweep_len(MEM_BLOCKS_CNT, MEM_BLOCKS_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  assign valid_o = active_q;
  assign block_o = cnt_q[CNT_W-1:MEM_BLOCKS_W];
  assign addr_o  = cnt_q[MEM_BLOCKS_W-1:0];
  assign last_o  = active_q && (cnt_q == CNT_W'(SWEEP_LEN - 1));
  assign done_o  = done_q;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = last_o;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (last_o) active_d = 1'b0;
      else        cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: rtl/hash_lut_loader.sv
// rtl/hash_lut_loader.sv - clears then programs the hash_lut bit memory over an Avalon-MM write port
// Optional write-one counter output wr_cnt_o under HASH_LUT_LOADER_WR_CNT_EN.
module hash_lut_loader
  import hash_lut_loader_pkg::*;
#(
  parameter int unsigned AMM_LUT_ADDR_W = 32,
  parameter int unsigned AMM_LUT_DATA_W = 32,
  parameter int unsigned MEM_BLOCKS_CNT = 78,
  parameter int unsigned MEM_BLOCKS_W   = 13,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic                              clk_i,
  input  logic                              srst_n_i,
  input  logic                              cfg_start_i,
  input  logic                              cfg_done_i,
  input  logic                              set_valid_i,
  output logic                              set_ready_o,
  input  logic [$clog2(MEM_BLOCKS_CNT)-1:0] set_block_i,
  input  logic [MEM_BLOCKS_W-1:0]           set_addr_i,
  input  logic                              set_val_i,
  output logic                              config_o,
  output logic [AMM_LUT_ADDR_W-1:0]         amm_master_lut_address_o,
  output logic                              amm_master_lut_write_o,
  output logic [AMM_LUT_DATA_W-1:0]         amm_master_lut_writedata_o,
  output logic                              busy_o,
  output logic                              clear_done_o,
  output logic                              err_o
`ifdef HASH_LUT_LOADER_WR_CNT_EN
  ,
  output logic [31:0]                       wr_cnt_o
`endif
);

  localparam int unsigned BLK_W    = $clog2(MEM_BLOCKS_CNT);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 2);

  ldr_state_e                state_q, state_d;
  logic [AMM_LUT_ADDR_W-1:0] addr_q, addr_d;
  logic [AMM_LUT_DATA_W-1:0] data_q, data_d;
  logic                      write_q, write_d;
  logic                      config_q, config_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;
  logic                      clear_done_q, clear_done_d;
  logic                      err_q, err_d;
  logic [SETTLE_W-1:0]       settle_q, settle_d;
`ifdef HASH_LUT_LOADER_WR_CNT_EN
  logic [31:0]               wr_cnt_q, wr_cnt_d;
`endif

  logic                    sweep_start;
  logic                    sweep_valid;
  logic [BLK_W-1:0]        sweep_block;
  logic [MEM_BLOCKS_W-1:0] sweep_addr;
  logic                    sweep_last;
  logic                    sweep_done;
  logic                    handshake;
  logic                    blk_ok;

  lut_clear_sweeper #(
    .MEM_BLOCKS_CNT(MEM_BLOCKS_CNT),
    .MEM_BLOCKS_W  (MEM_BLOCKS_W),
    .BLK_W         (BLK_W)
  ) u_sweeper (
    .clk_i   (clk_i),
    .srst_n_i(srst_n_i),
    .start_i (sweep_start),
    .valid_o (sweep_valid),
    .block_o (sweep_block),
    .addr_o  (sweep_addr),
    .last_o  (sweep_last),
    .done_o  (sweep_done)
  );

  assign handshake = set_valid_i && ready_q;
  assign blk_ok    = 32'(set_block_i) < MEM_BLOCKS_CNT;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    write_d      = 1'b0;
    clear_done_d = sweep_done;
    err_d        = err_q;
    settle_d     = settle_q;
    sweep_start  = 1'b0;
`ifdef HASH_LUT_LOADER_WR_CNT_EN
    wr_cnt_d     = wr_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          state_d     = ST_CLEAR;
          sweep_start = 1'b1;
          err_d       = 1'b0;
`ifdef HASH_LUT_LOADER_WR_CNT_EN
          wr_cnt_d    = '0;
`endif
        end
      end
      ST_CLEAR: begin
        if (sweep_valid) begin
          write_d = 1'b1;
          addr_d  = AMM_LUT_ADDR_W'(pack_lut_addr(32'(sweep_block), 32'(sweep_addr), MEM_BLOCKS_W));
          data_d  = '0;
        end
        if (clear_done_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (handshake) begin
          if (blk_ok) begin
            write_d = 1'b1;
            addr_d  = AMM_LUT_ADDR_W'(pack_lut_addr(32'(set_block_i), 32'(set_addr_i), MEM_BLOCKS_W));
            data_d  = AMM_LUT_DATA_W'(set_val_i);
`ifdef HASH_LUT_LOADER_WR_CNT_EN
            if (set_val_i && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_d = wr_cnt_q + 32'd1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        if (cfg_done_i) begin
          state_d  = ST_DRAIN;
          settle_d = '0;
        end
      end
      ST_DRAIN: begin
        // A write issued on the closing handshake is still on the bus; settle counting starts after it.
        if (!write_q) begin
          if (32'(settle_q) + 32'd1 >= SETTLE_CYCLES) state_d  = ST_IDLE;
          else                                         settle_d = settle_q + SETTLE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    config_d = (state_d != ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    ready_d  = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      config_q     <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      clear_done_q <= 1'b0;
      err_q        <= 1'b0;
      settle_q     <= '0;
`ifdef HASH_LUT_LOADER_WR_CNT_EN
      wr_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      write_q      <= write_d;
      config_q     <= config_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      clear_done_q <= clear_done_d;
      err_q        <= err_d;
      settle_q     <= settle_d;
`ifdef HASH_LUT_LOADER_WR_CNT_EN
      wr_cnt_q     <= wr_cnt_d;
`endif
    end
  end

  assign set_ready_o                = ready_q;
  assign config_o                   = config_q;
  assign amm_master_lut_address_o   = addr_q;
  assign amm_master_lut_write_o     = write_q;
  assign amm_master_lut_writedata_o = data_q;
  assign busy_o                     = busy_q;
  assign clear_done_o               = clear_done_q;
  assign err_o                      = err_q;
`ifdef HASH_LUT_LOADER_WR_CNT_EN
  assign wr_cnt_o                   = wr_cnt_q;
`endif

  logic unused_last;
  assign unused_last = sweep_last;

endmodule

// File: tb/tb_hash_lut_loader.sv
// tb/tb_hash_lut_loader.sv - directed self-checking bench for hash_lut_loader (3 blocks x 16 bits)
module tb_hash_lut_loader;

  localparam int CNT = 3;
  localparam int W   = 4;
  localparam int SET = 2;

  logic        clk_i = 1'b0;
  logic        srst_n_i = 1'b0;
  logic        cfg_start_i = 1'b0;
  logic        cfg_done_i = 1'b0;
  logic        set_valid_i = 1'b0;
  logic        set_ready_o;
  logic [1:0]  set_block_i = '0;
  logic [3:0]  set_addr_i = '0;
  logic        set_val_i = 1'b0;
  logic        config_o;
  logic [31:0] address_o;
  logic        write_o;
  logic [31:0] writedata_o;
  logic        busy_o;
  logic        clear_done_o;
  logic        err_o;
`ifdef HASH_LUT_LOADER_WR_CNT_EN
  logic [31:0] wr_cnt_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  hash_lut_loader #(
    .AMM_LUT_ADDR_W(32),
    .AMM_LUT_DATA_W(32),
    .MEM_BLOCKS_CNT(CNT),
    .MEM_BLOCKS_W  (W),
    .SETTLE_CYCLES (SET)
  ) dut (
    .clk_i                     (clk_i),
    .srst_n_i                  (srst_n_i),
    .cfg_start_i               (cfg_start_i),
    .cfg_done_i                (cfg_done_i),
    .set_valid_i               (set_valid_i),
    .set_ready_o               (set_ready_o),
    .set_block_i               (set_block_i),
    .set_addr_i                (set_addr_i),
    .set_val_i                 (set_val_i),
    .config_o                  (config_o),
    .amm_master_lut_address_o  (address_o),
    .amm_master_lut_write_o    (write_o),
    .amm_master_lut_writedata_o(writedata_o),
    .busy_o                    (busy_o),
    .clear_done_o              (clear_done_o),
    .err_o                     (err_o)
`ifdef HASH_LUT_LOADER_WR_CNT_EN
    ,
    .wr_cnt_o                  (wr_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    srst_n_i = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({config_o, write_o, busy_o, set_ready_o, clear_done_o, err_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got cfg/wr/busy/rdy/cd/err=%b required 000000",
               {config_o, write_o, busy_o, set_ready_o, clear_done_o, err_o});
    end
    tests_run++;
    if (address_o !== 32'h0 || writedata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr=%h data=%h required 0/0", address_o, writedata_o);
    end
    srst_n_i = 1'b1;
    tick();
    tests_run++;
    if (busy_o !== 1'b0 || config_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b cfg=%b required 0/0", busy_o, config_o);
    end
  endtask

  task automatic test_idle_done_ignored();
    cfg_done_i = 1'b1;
    tick();
    cfg_done_i = 1'b0;
    tick();
    tests_run++;
    if (busy_o !== 1'b0 || config_o !== 1'b0 || write_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_done: got busy=%b cfg=%b wr=%b required 0/0/0", busy_o, config_o, write_o);
    end
  endtask

  task automatic test_clear_sweep();
    int pulses;
    pulses = 0;
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    tests_run++;
    if (config_o !== 1'b1 || busy_o !== 1'b1 || set_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_enter: got cfg=%b busy=%b rdy=%b required 1/1/0", config_o, busy_o, set_ready_o);
    end
    for (int i = 0; i < CNT * (1 << W); i++) begin
      tick();
      if (clear_done_o === 1'b1) pulses++;
      tests_run++;
      if (write_o !== 1'b1 || address_o !== 32'(i) || writedata_o !== 32'h0 || config_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL clear_write[%0d]: got wr=%b addr=%h data=%h cfg=%b required 1/%h/0/1",
                 i, write_o, address_o, writedata_o, config_o, 32'(i));
      end
    end
    tick();
    if (clear_done_o === 1'b1) pulses++;
    tests_run++;
    if (write_o !== 1'b0 || clear_done_o !== 1'b1 || set_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_done_pulse: got wr=%b cd=%b rdy=%b required 0/1/0", write_o, clear_done_o, set_ready_o);
    end
    tick();
    if (clear_done_o === 1'b1) pulses++;
    tests_run++;
    if (set_ready_o !== 1'b1 || config_o !== 1'b1 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_enter: got rdy=%b cfg=%b busy=%b required 1/1/1", set_ready_o, config_o, busy_o);
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL clear_done_count: got %0d pulses required 1", pulses);
    end
  endtask

  task automatic test_load_back_to_back();
    set_valid_i = 1'b1;
    set_block_i = 2'd2;
    set_addr_i  = 4'd5;
    set_val_i   = 1'b1;
    tick();
    set_block_i = 2'd1;
    set_addr_i  = 4'hA;
    set_val_i   = 1'b0;
    tests_run++;
    if (write_o !== 1'b1 || address_o !== 32'h25 || writedata_o !== 32'h1) begin
      tests_failed++;
      $display("FAIL load_first: got wr=%b addr=%h data=%h required 1/00000025/00000001", write_o, address_o, writedata_o);
    end
    tick();
    set_valid_i = 1'b0;
    tests_run++;
    if (write_o !== 1'b1 || address_o !== 32'h1A || writedata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL load_second: got wr=%b addr=%h data=%h required 1/0000001a/00000000", write_o, address_o, writedata_o);
    end
    tick();
    tests_run++;
    if (write_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_idle_bus: got wr=%b required 0", write_o);
    end
  endtask

  task automatic test_bad_block();
    set_valid_i = 1'b1;
    set_block_i = 2'd3;
    set_addr_i  = 4'd0;
    set_val_i   = 1'b1;
    tick();
    set_valid_i = 1'b0;
    tests_run++;
    if (write_o !== 1'b0 || err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_block: got wr=%b err=%b required 0/1", write_o, err_o);
    end
    tick();
    tick();
    tests_run++;
    if (err_o !== 1'b1 || set_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got err=%b rdy=%b required 1/1", err_o, set_ready_o);
    end
  endtask

  task automatic test_done_with_request();
    set_valid_i = 1'b1;
    set_block_i = 2'd0;
    set_addr_i  = 4'd3;
    set_val_i   = 1'b1;
    cfg_done_i  = 1'b1;
    tick();
    set_valid_i = 1'b0;
    cfg_done_i  = 1'b0;
    tests_run++;
    if (write_o !== 1'b1 || address_o !== 32'h03 || config_o !== 1'b1 || set_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_last_write: got wr=%b addr=%h cfg=%b rdy=%b required 1/00000003/1/0",
               write_o, address_o, config_o, set_ready_o);
    end
    for (int i = 0; i < SET; i++) begin
      tick();
      tests_run++;
      if (config_o !== 1'b1 || write_o !== 1'b0 || busy_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL drain_settle[%0d]: got cfg=%b wr=%b busy=%b required 1/0/1", i, config_o, write_o, busy_o);
      end
    end
    tick();
    tests_run++;
    if (config_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_exit: got cfg=%b busy=%b err=%b required 0/0/1", config_o, busy_o, err_o);
    end
  endtask

  task automatic test_start_clears_err();
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    tests_run++;
    if (err_o !== 1'b0 || config_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_clears_err: got err=%b cfg=%b required 0/1", err_o, config_o);
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 10; i++) tick();
    tests_run++;
    if (write_o !== 1'b1 || address_o !== 32'd9) begin
      tests_failed++;
      $display("FAIL mid_clear_pos: got wr=%b addr=%h required 1/00000009", write_o, address_o);
    end
    srst_n_i = 1'b0;
    tick();
    srst_n_i = 1'b1;
    tests_run++;
    if ({config_o, write_o, busy_o, set_ready_o, clear_done_o, err_o} !== 6'b0 ||
        address_o !== 32'h0 || writedata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_clear_reset: got flags=%b addr=%h data=%h required 000000/0/0",
               {config_o, write_o, busy_o, set_ready_o, clear_done_o, err_o}, address_o, writedata_o);
    end
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    tick();
    tests_run++;
    if (write_o !== 1'b1 || address_o !== 32'h0 || config_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_sweep: got wr=%b addr=%h cfg=%b required 1/00000000/1", write_o, address_o, config_o);
    end
  endtask

  task automatic test_count_session();
    logic [6:0] vals;
    int         waited;
    vals   = 7'b1101101;
    waited = 0;
    while (set_ready_o !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    tests_run++;
    if (set_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_load: got rdy=%b after %0d cycles required 1", set_ready_o, waited);
    end
    for (int i = 0; i < 7; i++) begin
      set_valid_i = 1'b1;
      set_block_i = 2'(i % 3);
      set_addr_i  = 4'(i);
      set_val_i   = vals[i];
      cfg_done_i  = (i == 6);
      tick();
      tests_run++;
      if (write_o !== 1'b1 || address_o !== ((32'(i % 3) << 4) | 32'(i)) || writedata_o !== 32'(vals[i])) begin
        tests_failed++;
        $display("FAIL count_req[%0d]: got wr=%b addr=%h data=%h required 1/%h/%h",
                 i, write_o, address_o, writedata_o, (32'(i % 3) << 4) | 32'(i), 32'(vals[i]));
      end
    end
    set_valid_i = 1'b0;
    cfg_done_i  = 1'b0;
    for (int i = 0; i < SET + 1; i++) tick();
    tests_run++;
    if (busy_o !== 1'b0 || config_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL count_drain: got busy=%b cfg=%b required 0/0", busy_o, config_o);
    end
`ifdef HASH_LUT_LOADER_WR_CNT_EN
    tests_run++;
    if (wr_cnt_o !== 32'd5) begin
      tests_failed++;
      $display("FAIL wr_cnt: got %0d required 5", wr_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_idle_done_ignored();
    test_clear_sweep();
    test_load_back_to_back();
    test_bad_block();
    test_done_with_request();
    test_start_clears_err();
    test_reset_mid_clear();
    test_count_session();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
